// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 LCD writer.
// Contents: controller state enum, power-on init byte/delay tables,
// delay constants in microseconds and a helper that picks the execution
// delay for a user-written byte.
package hd44780_pkg;

  typedef enum logic [2:0] {
    ST_POWER_WAIT,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } state_e;

  localparam int unsigned POWER_US = 40000;
  localparam int unsigned SETUP_US = 1;
  localparam int unsigned PULSE_US = 1;
  localparam int unsigned HOLD_US  = 1;
  localparam int unsigned SHORT_US = 40;
  localparam int unsigned LONG_US  = 1640;
  localparam int unsigned INIT0_US = 4100;
  localparam int unsigned INIT1_US = 100;

  localparam int unsigned INIT_STEPS = 7;

  // 8-bit mode function set (x4), display on, clear, entry mode increment
  localparam logic [7:0] INIT_BYTE [INIT_STEPS] = '{
    8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06
  };

  localparam int unsigned INIT_DLY_US [INIT_STEPS] = '{
    INIT0_US, INIT1_US, SHORT_US, SHORT_US, SHORT_US, LONG_US, SHORT_US
  };

  // Clear display / return home need the long execution time.
  function automatic int unsigned user_dly_us(input logic is_cmd, input logic [7:0] d);
    return (is_cmd && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LONG_US : SHORT_US;
  endfunction

endpackage

// File: rtl/hd44780_lcd_writer.sv
// Write-only HD44780 controller, 8-bit bus mode.
// Runs the power-on init sequence after reset, then accepts one byte at a
// time over valid/ready and strobes it onto the LCD pins.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   valid, is_cmd, data upstream byte (is_cmd=1 -> instruction, RS=0)
//   ready               byte accepted on an edge with valid & ready
//   init_done           init sequence finished, sticky until reset
//   lcd_rs/rw/e/d       LCD header pins (rw tied 0)
module hd44780_lcd_writer
  import hd44780_pkg::*;
#(
  parameter int unsigned clk_mhz = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic       is_cmd,
  input  logic [7:0] data,
  output logic       ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_d
);

  localparam int unsigned CW = $clog2(POWER_US * clk_mhz + 1);
  localparam logic [2:0] LAST_STEP = 3'(INIT_STEPS - 1);

  typedef logic [CW-1:0] cnt_t;

  // Counter is loaded with N-1 so the state lasts exactly N cycles.
  function automatic cnt_t load(input int unsigned us);
    return cnt_t'(us * clk_mhz - 1);
  endfunction

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [2:0] step_q, step_d;
  logic [2:0] step_inc;
  logic [7:0] data_q, data_d;
  logic       rs_q, rs_d;
  logic       init_done_q, init_done_d;

  assign step_inc = step_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_POWER_WAIT;
      cnt_q       <= load(POWER_US);
      step_q      <= '0;
      data_q      <= '0;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - cnt_t'(1) : cnt_q;
    step_d      = step_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_POWER_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_SETUP;
          cnt_d   = load(SETUP_US);
          step_d  = '0;
          data_d  = INIT_BYTE[0];
          rs_d    = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = load(PULSE_US);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = load(HOLD_US);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_EXEC;
          // rs_q holds ~is_cmd of the captured byte
          cnt_d   = init_done_q ? load(user_dly_us(~rs_q, data_q))
                                : load(INIT_DLY_US[step_q]);
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (step_q == LAST_STEP) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = load(SETUP_US);
            step_d  = step_inc;
            data_d  = INIT_BYTE[step_inc];
            rs_d    = 1'b0;
          end
        end
      end
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_SETUP;
          cnt_d   = load(SETUP_US);
          data_d  = data;
          rs_d    = ~is_cmd;
        end
      end
      default: state_d = ST_POWER_WAIT;
    endcase
  end

  always_comb begin
    ready     = (state_q == ST_IDLE);
    init_done = init_done_q;
    lcd_e     = (state_q == ST_PULSE);
    lcd_rs    = rs_q;
    lcd_rw    = 1'b0;
    lcd_d     = data_q;
  end

endmodule

// File: doc/hd44780_lcd_writer.md
# hd44780_lcd_writer

Write-only controller for an HD44780-compatible character LCD in 8-bit bus mode, driving the board's `LCD_RS`, `LCD_RW`, `LCD_E` and `LCD_D` header pins.
- After reset it runs the standard power-on initialisation sequence on its own.
- After that it accepts one command or character byte at a time over a valid/ready handshake.
- It sits between `lab_top` (the producer of text/commands) and the LCD pins in `board_specific_top`, as an alternative to using those pins as GPIO.

## Interface
Parameters:
- `clk_mhz`, 50: clock frequency in MHz. All delays are specified in µs and scaled by this value.

Ports:
- `clk`: input, 1. System clock.
- `rst_n`: input, 1. Reset, asynchronous and active-low.
- `valid`: input, 1. Upstream has a byte to write.
- `is_cmd`: input, 1. 1 = instruction (RS=0); 0 = character data (RS=1).
- `data`: input, 8. Byte to write.
- `ready`: output, 1. Block can accept a byte this cycle.
- `init_done`: output, 1. Initialisation sequence complete; stays high until reset.
- `lcd_rs`: output, 1. Register select.
- `lcd_rw`: output, 1. Read/write; constantly 0.
- `lcd_e`: output, 1. Enable strobe.
- `lcd_d`: output, 8. Data bus.

## Operation
Reset values (asserted asynchronously while `rst_n`=0):
- `ready`=0, `init_done`=0.
- `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `lcd_d`=8'h00.
- State = POWER_WAIT.

States:
- POWER_WAIT: waits 40000 µs, then starts init step 0.
- SETUP: `lcd_rs`/`lcd_d` are valid and `lcd_e`=0, for 1 µs.
- PULSE: `lcd_e`=1 for 1 µs.
- HOLD: `lcd_e`=0 with bus held for 1 µs.
- EXEC: bus held and waits the execution delay. Then goes to the next init step, or to IDLE after the last step.
- IDLE: `ready`=1.

Init sequence (all RS=0), as byte / EXEC delay:
- 8'h38 / 4100 µs
- 8'h38 / 100 µs
- 8'h38 / 40 µs
- 8'h38 / 40 µs
- 8'h0C / 40 µs
- 8'h01 / 1640 µs
- 8'h06 / 40 µs

`init_done` rises on entry to IDLE after step 6.

Handshake:
- A transfer occurs on a rising edge with `valid`=1 and `ready`=1.
- `is_cmd` and `data` are captured on that edge. The state moves to SETUP and `ready` falls on that same edge.
- `valid` while `ready`=0 is ignored. Nothing is captured and no error is flagged.
- Upstream may change `data` freely after the accept edge.

User EXEC delay:
- 1640 µs if `is_cmd`=1 and `data` is 8'h01, 8'h02 or 8'h03 (clear / return home).
- 40 µs otherwise.

Bus values:
- `lcd_rs` = ~`is_cmd` captured.
- `lcd_d` keeps the last written value through IDLE.

## Timing
- One µs = `clk_mhz` cycles. A delay of N µs is exactly N·`clk_mhz` cycles in the state.
- A single down-counter is loaded on state entry. Its width is $clog2(40000·`clk_mhz`+1), which is 21 bits at 50 MHz.
- Accept edge at cycle T:
  - `lcd_d`/`lcd_rs` are valid from T.
  - `lcd_e` is high for cycles [T+clk_mhz, T+2·clk_mhz).
  - `ready` returns high at T + (3 + D)·clk_mhz, where D is the EXEC delay in µs.
- Back-to-back: with `valid` held, the next accept occurs in the first cycle `ready`=1. No extra idle cycle.
- Reset mid-transfer:
  - All outputs return to reset values immediately; `lcd_e` drops asynchronously.
  - The in-flight byte is discarded.
  - The full power-on sequence reruns after `rst_n` rises.
- Counter reload happens on the transition edge. A 0-length state is never produced (minimum delay 1 µs).

## Structure
- Package `hd44780_pkg`:
  - state enum;
  - init byte array and per-step delay array (7 entries);
  - µs constants (POWER 40000, SETUP/PULSE/HOLD 1, SHORT 40, LONG 1640, INIT0 4100, INIT1 100).
- Single module; no sub-module. The init step index is 3 bits and the init sequence is sourced from package constants.
- Board top ties `lcd_rw` to `LCD_RW`, and `lcd_d` to `LCD_D`.

## Test plan
Run with `clk_mhz`=1 for speed.

1. Reset release:
   - Stimulus: release `rst_n`.
   - Required: all outputs 0 for 40000 cycles.
   - Required: first `lcd_e` rise at cycle 40001, with `lcd_d`=8'h38 and `lcd_rs`=0.
2. Full init:
   - Required: exactly 7 E pulses carrying 38,38,38,38,0C,01,06.
   - Required: E-rise spacing matches 3+delay µs.
   - Required: `init_done`=`ready`=1 after the final EXEC.
3. Character write:
   - Stimulus: `is_cmd`=0, `data`=8'h41 ("A") accepted at T.
   - Required: `lcd_rs`=1 and `lcd_d`=8'h41 at T.
   - Required: `lcd_e` high only in cycle T+1.
   - Required: `ready` high at T+43.
4. Clear command:
   - Stimulus: `is_cmd`=1, `data`=8'h01 at T.
   - Required: `ready` returns at T+1643.
   - Repeat with 8'h80 → `ready` returns at T+43.
5. Busy ignore:
   - Stimulus: pulse `valid` with 8'h55 while `ready`=0.
   - Required: no extra E pulse; bus keeps the prior byte.
6. Mid-pulse reset:
   - Stimulus: assert `rst_n`=0 while `lcd_e`=1.
   - Required: `lcd_e`=0 within the same cycle, `ready`=0, `init_done`=0.
   - Required: the power wait restarts at 40000 cycles.
